// File: rtl/demux_n_clk_pkg.sv
// Shared types and constants for the clocked M-way bundled-data demux.
package demux_n_clk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    RTZ  = 2'd3
  } dmx_state_t;

  // Invalid-select policy: drop the token with an error strobe, or steer it to the last output.
  localparam int unsigned BAD_SEL_DROP = 0;
  localparam int unsigned BAD_SEL_LAST = 1;

endpackage

// File: rtl/demux_n_clk_if.sv
// Handshake bundle of the demux: input channel, select channel, M output channels.
interface demux_n_clk_if #(
  parameter int unsigned N = 32,
  parameter int unsigned M = 4
);
  localparam int unsigned SW = $clog2(M);

  logic          r_i;
  logic          a_i;
  logic [N-1:0]  d_i;
  logic          ctl_r;
  logic [SW-1:0] ctl_sel;
  logic          actl_i;
  logic [M-1:0]  r_o;
  logic [M-1:0]  a_o;
  logic [N-1:0]  d_o;
  logic          err_o;

  // Environment side: drives requests/data/select and the output acknowledges.
  modport master (
    output r_i, d_i, ctl_r, ctl_sel, a_o,
    input  a_i, actl_i, r_o, d_o, err_o
  );

  // Demux side.
  modport slave (
    input  r_i, d_i, ctl_r, ctl_sel, a_o,
    output a_i, actl_i, r_o, d_o, err_o
  );

endinterface

// File: rtl/demux_n_clk_sync_ff.sv
// W-bit synchroniser chain, STAGES deep, async reset to 0; STAGES=0 is a plain wire.
module demux_n_clk_sync_ff #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned W      = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (STAGES == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign q = d;
    end else begin : g_chain
      logic [W-1:0] chain [STAGES];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned i = 0; i < STAGES; i++) chain[i] <= '0;
        end else begin
          chain[0] <= d;
          for (int unsigned i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
      end

      assign q = chain[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/demux_n_clk.sv
// Clocked M-way demux of a 4-phase bundled-data channel, steered by a joined select channel.
module demux_n_clk
  import demux_n_clk_pkg::*;
#(
  parameter int unsigned N           = 32,
  parameter int unsigned M           = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned BAD_SEL     = BAD_SEL_DROP
) (
  input logic          clk,
  input logic          rst,
  demux_n_clk_if.slave bus
);

  localparam int unsigned SW       = $clog2(M);
  localparam int unsigned PW       = 1 << SW;
  localparam logic [SW:0]   M_LIM    = (SW+1)'(M);
  localparam logic [SW-1:0] SEL_LAST = SW'(M - 1);

  dmx_state_t    state, state_n;
  logic [SW-1:0] sel_q, sel_n;
  logic [N-1:0]  d_q, d_n;
  logic [M-1:0]  r_q, r_n;
  logic          a_q, a_n;
  logic          err_q;
  logic          err_pend, err_pend_n;
  logic          drop_q, drop_n;

  logic [1:0]    req_s;
  logic [M-1:0]  ack_s;
  logic [PW-1:0] ack_pad;
  logic          rs, cs, sel_ok;

  demux_n_clk_sync_ff #(.STAGES(SYNC_STAGES), .W(2)) u_sync_req (
    .clk (clk),
    .rst (rst),
    .d   ({bus.r_i, bus.ctl_r}),
    .q   (req_s)
  );

  demux_n_clk_sync_ff #(.STAGES(SYNC_STAGES), .W(M)) u_sync_ack (
    .clk (clk),
    .rst (rst),
    .d   (bus.a_o),
    .q   (ack_s)
  );

  assign rs      = req_s[1];
  assign cs      = req_s[0];
  // Padded so any select code can index it; only the selected bit is ever looked at.
  assign ack_pad = PW'(ack_s);
  assign sel_ok  = (SW+1)'(bus.ctl_sel) < M_LIM;

  function automatic logic [M-1:0] onehot(input logic [SW-1:0] s);
    return M'(1) << s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= '0;
      d_q      <= '0;
      r_q      <= '0;
      a_q      <= 1'b0;
      err_q    <= 1'b0;
      err_pend <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state    <= state_n;
      sel_q    <= sel_n;
      d_q      <= d_n;
      r_q      <= r_n;
      a_q      <= a_n;
      err_q    <= err_pend;
      err_pend <= err_pend_n;
      drop_q   <= drop_n;
    end
  end

  // Outputs are registered from the current state, so each handshake edge costs one extra cycle.
  always_comb begin
    state_n    = state;
    sel_n      = sel_q;
    d_n        = d_q;
    drop_n     = drop_q;
    err_pend_n = 1'b0;
    r_n        = '0;
    a_n        = 1'b0;

    case (state)
      IDLE: begin
        if (rs && cs) begin
          d_n     = bus.d_i;
          drop_n  = 1'b0;
          state_n = REQ;
          if (sel_ok) begin
            sel_n = bus.ctl_sel;
          end else if (BAD_SEL == BAD_SEL_LAST) begin
            sel_n = SEL_LAST;
          end else begin
            sel_n      = bus.ctl_sel;
            drop_n     = 1'b1;
            err_pend_n = 1'b1;
            state_n    = ACK;
          end
        end
      end
      REQ: begin
        r_n = onehot(sel_q);
        if (ack_pad[sel_q]) state_n = ACK;
      end
      ACK: begin
        r_n = drop_q ? '0 : onehot(sel_q);
        a_n = 1'b1;
        if (!rs && !cs) state_n = RTZ;
      end
      RTZ: begin
        a_n = 1'b1;
        if (drop_q || !ack_pad[sel_q]) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.r_o    = r_q;
  assign bus.a_i    = a_q;
  assign bus.actl_i = a_q;
  assign bus.d_o    = d_q;
  assign bus.err_o  = err_q;

endmodule

// File: tb/tb_demux_n_clk.sv
// Bench for demux_n_clk: four configurations driven from one table of channel variables.
module tb_demux_n_clk;

  localparam int W_REQ = 0;
  localparam int W_ACK = 1;
  localparam int W_RLO = 2;
  localparam int W_ALO = 3;
  localparam int BOUND = 30;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance k: 0 = M4/SYNC0/drop, 1 = M5/SYNC0/drop, 2 = M5/SYNC0/last, 3 = M4/SYNC2/drop
  logic       r_i   [4];
  logic       ctl_r [4];
  logic [7:0] d_i   [4];
  logic [2:0] sel   [4];
  logic [4:0] a_o   [4];
  logic       a_i   [4];
  logic       actl  [4];
  logic [4:0] r_o   [4];
  logic [7:0] d_o   [4];
  logic       err   [4];

  int total = 0;
  int pass_cnt = 0;
  int proto_errs = 0;

  demux_n_clk_if #(.N(8), .M(4)) b0 ();
  demux_n_clk_if #(.N(8), .M(5)) b1 ();
  demux_n_clk_if #(.N(8), .M(5)) b2 ();
  demux_n_clk_if #(.N(8), .M(4)) b3 ();

  demux_n_clk #(.N(8), .M(4), .SYNC_STAGES(0), .BAD_SEL(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  demux_n_clk #(.N(8), .M(5), .SYNC_STAGES(0), .BAD_SEL(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
  demux_n_clk #(.N(8), .M(5), .SYNC_STAGES(0), .BAD_SEL(1)) u2 (.clk(clk), .rst(rst), .bus(b2));
  demux_n_clk #(.N(8), .M(4), .SYNC_STAGES(2), .BAD_SEL(0)) u3 (.clk(clk), .rst(rst), .bus(b3));

  assign b0.r_i = r_i[0];  assign b0.ctl_r = ctl_r[0];  assign b0.d_i = d_i[0];
  assign b1.r_i = r_i[1];  assign b1.ctl_r = ctl_r[1];  assign b1.d_i = d_i[1];
  assign b2.r_i = r_i[2];  assign b2.ctl_r = ctl_r[2];  assign b2.d_i = d_i[2];
  assign b3.r_i = r_i[3];  assign b3.ctl_r = ctl_r[3];  assign b3.d_i = d_i[3];
  assign b0.ctl_sel = sel[0][1:0];  assign b0.a_o = a_o[0][3:0];
  assign b1.ctl_sel = sel[1];       assign b1.a_o = a_o[1];
  assign b2.ctl_sel = sel[2];       assign b2.a_o = a_o[2];
  assign b3.ctl_sel = sel[3][1:0];  assign b3.a_o = a_o[3][3:0];

  assign a_i[0] = b0.a_i;  assign actl[0] = b0.actl_i;  assign r_o[0] = {1'b0, b0.r_o};
  assign a_i[1] = b1.a_i;  assign actl[1] = b1.actl_i;  assign r_o[1] = b1.r_o;
  assign a_i[2] = b2.a_i;  assign actl[2] = b2.actl_i;  assign r_o[2] = b2.r_o;
  assign a_i[3] = b3.a_i;  assign actl[3] = b3.actl_i;  assign r_o[3] = {1'b0, b3.r_o};
  assign d_o[0] = b0.d_o;  assign d_o[1] = b1.d_o;  assign d_o[2] = b2.d_o;  assign d_o[3] = b3.d_o;
  assign err[0] = b0.err_o; assign err[1] = b1.err_o; assign err[2] = b2.err_o; assign err[3] = b3.err_o;

  // r_o must be one-hot-or-zero and actl_i must mirror a_i on every instance
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if ($countones(r_o[k]) > 1 || a_i[k] !== actl[k]) proto_errs++;
    end
  end

  function automatic int m_of(input int k);
    return (k == 1 || k == 2) ? 5 : 4;
  endfunction

  function automatic int sync_of(input int k);
    return (k == 3) ? 2 : 0;
  endfunction

  // Reference routing: output index for a select code, or -1 when the token is dropped.
  function automatic int route(input int k, input int s);
    if (s < m_of(k)) return s;
    if (k == 2) return m_of(k) - 1;
    return -1;
  endfunction

  function automatic logic cond(input int k, input int what);
    case (what)
      W_REQ:   return r_o[k] != 5'b0;
      W_ACK:   return a_i[k];
      W_RLO:   return r_o[k] == 5'b0;
      default: return !a_i[k];
    endcase
  endfunction

  task automatic wait_for(input int k, input int what, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cond(k, what) && n < BOUND);
  endtask

  task automatic xfer(input int k, input logic [7:0] data, input logic [2:0] s, input string tag);
    int ch, lat, n, exp_n;
    logic [4:0] exp_r;
    ch    = route(k, int'(s));
    lat   = 2 + sync_of(k);
    exp_r = (ch < 0) ? 5'b0 : 5'(1 << ch);
    d_i[k] = data; sel[k] = s; r_i[k] = 1'b1; ctl_r[k] = 1'b1;
    if (ch >= 0) begin
      wait_for(k, W_REQ, n);
      total++;
      if (n != lat || r_o[k] !== exp_r)
        $display("FAIL %s req k=%0d r_o got %b want %b, cycles got %0d want %0d", tag, k, r_o[k], exp_r, n, lat);
      else pass_cnt++;
      total++;
      if (d_o[k] !== data) $display("FAIL %s data k=%0d d_o got %h want %h", tag, k, d_o[k], data);
      else pass_cnt++;
      d_i[k] = ~data;
      a_o[k] = exp_r;
      wait_for(k, W_ACK, n);
      total++;
      if (n != lat || actl[k] !== 1'b1 || r_o[k] !== exp_r || d_o[k] !== data)
        $display("FAIL %s ack k=%0d cycles %0d/%0d actl %b r_o %b/%b d_o %h/%h",
                 tag, k, n, lat, actl[k], r_o[k], exp_r, d_o[k], data);
      else pass_cnt++;
    end else begin
      wait_for(k, W_ACK, n);
      total++;
      if (n != lat || err[k] !== 1'b1 || r_o[k] !== 5'b0)
        $display("FAIL %s drop k=%0d cycles got %0d want %0d err got %b want 1 r_o got %b want 0",
                 tag, k, n, lat, err[k], r_o[k]);
      else pass_cnt++;
      @(negedge clk);
      total++;
      if (err[k] !== 1'b0 || a_i[k] !== 1'b1 || r_o[k] !== 5'b0)
        $display("FAIL %s err_pulse k=%0d err got %b want 0 a_i got %b want 1 r_o %b", tag, k, err[k], a_i[k], r_o[k]);
      else pass_cnt++;
    end
    r_i[k] = 1'b0; ctl_r[k] = 1'b0;
    if (ch >= 0) begin
      wait_for(k, W_RLO, n);
      total++;
      if (n != lat || a_i[k] !== 1'b1)
        $display("FAIL %s rtz k=%0d cycles got %0d want %0d a_i got %b want 1", tag, k, n, lat, a_i[k]);
      else pass_cnt++;
      a_o[k] = 5'b0;
    end
    exp_n = (ch < 0) ? lat + 1 : lat;
    wait_for(k, W_ALO, n);
    total++;
    if (n != exp_n || r_o[k] !== 5'b0)
      $display("FAIL %s idle k=%0d cycles got %0d want %0d r_o got %b", tag, k, n, exp_n, r_o[k]);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({r_o[k], a_i[k], actl[k], d_o[k], err[k]} !== 16'h0)
        $display("FAIL reset k=%0d r_o=%b a_i=%b actl=%b d_o=%h err=%b want all 0",
                 k, r_o[k], a_i[k], actl[k], d_o[k], err[k]);
      else pass_cnt++;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    xfer(0, 8'hA5, 3'd2, "basic");
  endtask

  task automatic test_back_to_back();
    xfer(0, 8'h01, 3'd0, "b2b0");
    xfer(0, 8'h02, 3'd3, "b2b1");
    xfer(0, 8'h03, 3'd1, "b2b2");
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 3; k++) begin
        xfer(k, 8'($urandom), 3'($urandom_range(0, m_of(k) == 5 ? 7 : 3)), "rand");
      end
    end
  endtask

  task automatic test_join();
    d_i[0] = 8'h3C; sel[0] = 3'd1; r_i[0] = 1'b1; ctl_r[0] = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (r_o[0] !== 5'b0 || a_i[0] !== 1'b0)
      $display("FAIL join r_o got %b want 0 a_i got %b want 0", r_o[0], a_i[0]);
    else pass_cnt++;
    xfer(0, 8'h3C, 3'd1, "join");
  endtask

  task automatic test_bad_sel();
    xfer(1, 8'h5A, 3'd7, "bad_drop");
    xfer(1, 8'h11, 3'd4, "after_drop");
    xfer(2, 8'hC3, 3'd7, "bad_last");
  endtask

  task automatic test_wrong_ack();
    int n;
    d_i[0] = 8'h77; sel[0] = 3'd2; r_i[0] = 1'b1; ctl_r[0] = 1'b1;
    wait_for(0, W_REQ, n);
    a_o[0] = 5'b00010;
    repeat (6) @(negedge clk);
    total++;
    if (a_i[0] !== 1'b0 || r_o[0] !== 5'b00100)
      $display("FAIL wrong_ack a_i got %b want 0 r_o got %b want 00100", a_i[0], r_o[0]);
    else pass_cnt++;
    a_o[0] = 5'b00110;
    wait_for(0, W_ACK, n);
    total++;
    if (n != 2 || d_o[0] !== 8'h77)
      $display("FAIL right_ack cycles got %0d want 2 d_o got %h want 77", n, d_o[0]);
    else pass_cnt++;
    r_i[0] = 1'b0; ctl_r[0] = 1'b0;
    wait_for(0, W_RLO, n);
    a_o[0] = 5'b0;
    wait_for(0, W_ALO, n);
    total++;
    if (n != 2) $display("FAIL wrong_ack_rtz cycles got %0d want 2", n);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid(input int k);
    int n;
    xfer(k, 8'h9E, 3'd1, "pre_rst");
    d_i[k] = 8'hE7; sel[k] = 3'd3; r_i[k] = 1'b1; ctl_r[k] = 1'b1;
    wait_for(k, W_REQ, n);
    a_o[k] = 5'b01000;
    wait_for(k, W_ACK, n);
    #2 rst = 1'b1;
    #1;
    total++;
    if (r_o[k] !== 5'b0 || a_i[k] !== 1'b0 || d_o[k] !== 8'h00)
      $display("FAIL rst_mid k=%0d r_o got %b a_i got %b d_o got %h want 0", k, r_o[k], a_i[k], d_o[k]);
    else pass_cnt++;
    r_i[k] = 1'b0; ctl_r[k] = 1'b0; a_o[k] = 5'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    xfer(k, 8'($urandom), 3'($urandom_range(0, 3)), "post_rst");
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      r_i[k] = 1'b0; ctl_r[k] = 1'b0; d_i[k] = 8'h0; sel[k] = 3'd0; a_o[k] = 5'b0;
    end
    rst = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_join();
    test_bad_sel();
    test_wrong_ack();
    test_reset_mid(0);
    test_reset_mid(3);
    total++;
    if (proto_errs !== 0) $display("FAIL protocol one-hot/actl violations got %0d want 0", proto_errs);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
